// File: rtl/instr_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_frame_loader_if
// Description : Bundles the issue-side signals of instr_frame_loader:
//               instruction handshake, register-file read port, writeback
//               snoop, downstream stall, and the per-field frame outputs with
//               their write enables.
//               slave  modport : the loader itself
//               master modport : the surrounding logic (fetch, RF, frame reg)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_frame_loader_if #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int RESULT_SEL_W = 3
);
  // instruction handshake
  logic [31:0]             instr_in;
  logic                    instr_valid;
  logic                    instr_ready;
  // register file read port (1-cycle synchronous read)
  logic [REG_ADDR_W-1:0]   rf_raddr_a;
  logic [REG_ADDR_W-1:0]   rf_raddr_b;
  logic [DATA_W-1:0]       rf_rdata_a;
  logic [DATA_W-1:0]       rf_rdata_b;
  // writeback snoop
  logic                    wb_we;
  logic [REG_ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]       wb_data;
  // frame register side
  logic                    frame_stall;
  logic [DATA_W-1:0]       a_operand;
  logic [DATA_W-1:0]       b_operand;
  logic [DATA_W-1:0]       imm_val;
  logic [REG_ADDR_W-1:0]   a_loc;
  logic [REG_ADDR_W-1:0]   b_loc;
  logic [REG_ADDR_W-1:0]   write_sel;
  logic                    imm_sel;
  logic                    unsigned_sel;
  logic                    sub_en;
  logic                    write_en;
  logic [RESULT_SEL_W-1:0] result_sel;
  logic a_op_we, a_loc_we, b_op_we, b_loc_we, imm_we, imm_sel_we;
  logic unsigned_we, sub_en_we, result_sel_we, write_sel_we, write_en_we;
  logic                    illegal_instr;

  modport slave (
    input  instr_in, instr_valid, rf_rdata_a, rf_rdata_b,
           wb_we, wb_addr, wb_data, frame_stall,
    output instr_ready, rf_raddr_a, rf_raddr_b,
           a_operand, b_operand, imm_val, a_loc, b_loc, write_sel,
           imm_sel, unsigned_sel, sub_en, write_en, result_sel,
           a_op_we, a_loc_we, b_op_we, b_loc_we, imm_we, imm_sel_we,
           unsigned_we, sub_en_we, result_sel_we, write_sel_we, write_en_we,
           illegal_instr
  );

  modport master (
    output instr_in, instr_valid, rf_rdata_a, rf_rdata_b,
           wb_we, wb_addr, wb_data, frame_stall,
    input  instr_ready, rf_raddr_a, rf_raddr_b,
           a_operand, b_operand, imm_val, a_loc, b_loc, write_sel,
           imm_sel, unsigned_sel, sub_en, write_en, result_sel,
           a_op_we, a_loc_we, b_op_we, b_loc_we, imm_we, imm_sel_we,
           unsigned_we, sub_en_we, result_sel_we, write_sel_we, write_en_we,
           illegal_instr
  );
endinterface
`default_nettype wire

// File: rtl/instr_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_frame_loader
// Description : Issue-side sequencer filling the per-field instruction frame.
//               Accepts one RV32I word (OP, OP-IMM, LUI), reads rs1/rs2 from
//               the register file, registers the decoded frame and raises
//               the field write enables for one unstalled ISSUE cycle.
//               Sequence: IDLE -> READ -> CAPTURE -> ISSUE -> IDLE.
// Ports       : clk, reset (synchronous, active-high)
//               bus (instr_frame_loader_if.slave): handshake, RF read port,
//               writeback snoop, frame stall, frame fields + write enables,
//               illegal_instr pulse.
// Options     : INSTR_FRAME_FORWARD_EN - when defined, writeback data seen
//               in CAPTURE replaces the RF read data of a matching rs.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_frame_loader #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int RESULT_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_frame_loader_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READ    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ISSUE   = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [1:0]              state_q, state_d;
  logic [31:0]             instr_q;

  logic [DATA_W-1:0]       a_operand_q, b_operand_q, imm_val_q;
  logic [REG_ADDR_W-1:0]   a_loc_q, b_loc_q, write_sel_q;
  logic                    imm_sel_q, unsigned_sel_q, sub_en_q, write_en_q;
  logic [RESULT_SEL_W-1:0] result_sel_q;
  logic                    illegal_q;

  // ---------------- decode of the latched instruction ----------------------
  logic [6:0]              w_opcode;
  logic [2:0]              w_funct3;
  logic                    w_f7b5;
  logic [REG_ADDR_W-1:0]   w_rs1, w_rs2, w_rd;
  logic                    w_is_op, w_is_op_imm, w_is_lui, w_legal;
  logic [RESULT_SEL_W-1:0] w_result_sel;
  logic [DATA_W-1:0]       w_imm;
  logic [DATA_W-1:0]       w_a_src, w_b_src;

  assign w_opcode    = instr_q[6:0];
  assign w_rd        = instr_q[11:7];
  assign w_funct3    = instr_q[14:12];
  assign w_rs1       = instr_q[19:15];
  assign w_rs2       = instr_q[24:20];
  assign w_f7b5      = instr_q[30];
  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_is_op_imm = (w_opcode == OPC_OP_IMM);
  assign w_is_lui    = (w_opcode == OPC_LUI);
  assign w_legal     = w_is_op || w_is_op_imm || w_is_lui;

  always_comb begin
    w_result_sel = '0;
    case (w_funct3)
      3'b000:         w_result_sel = RESULT_SEL_W'(0);
      3'b111:         w_result_sel = RESULT_SEL_W'(1);
      3'b110:         w_result_sel = RESULT_SEL_W'(2);
      3'b100:         w_result_sel = RESULT_SEL_W'(3);
      3'b010, 3'b011: w_result_sel = RESULT_SEL_W'(4);
      3'b001:         w_result_sel = RESULT_SEL_W'(5);
      default:        w_result_sel = RESULT_SEL_W'(6);
    endcase
  end

  always_comb begin
    w_imm = '0;
    if (w_is_lui) begin
      w_imm = {instr_q[31:12], 12'b0};
    end else if (w_is_op_imm) begin
      // Shift immediates carry only the shamt; funct7 must not leak in.
      if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
        w_imm = {{(DATA_W-5){1'b0}}, instr_q[24:20]};
      else
        w_imm = {{(DATA_W-12){instr_q[31]}}, instr_q[31:20]};
    end
  end

  // Operand source: x0 always reads as zero, overriding RF and forwarding.
  always_comb begin
    w_a_src = bus.rf_rdata_a;
    w_b_src = bus.rf_rdata_b;
`ifdef INSTR_FRAME_FORWARD_EN
    if (bus.wb_we && bus.wb_addr == w_rs1) w_a_src = bus.wb_data;
    if (bus.wb_we && bus.wb_addr == w_rs2) w_b_src = bus.wb_data;
`endif
    if (w_rs1 == '0) w_a_src = '0;
    if (w_rs2 == '0) w_b_src = '0;
  end

`ifndef INSTR_FRAME_FORWARD_EN
  // Writeback snoop is present on the port list but has no effect here.
  logic w_unused_wb;
  assign w_unused_wb = ^{bus.wb_we, bus.wb_addr, bus.wb_data};
`endif

  // ---------------- FSM: state register ------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.instr_valid) state_d = S_READ;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ISSUE;
      S_ISSUE:   if (!bus.frame_stall) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs -------------------------------------------
  logic w_issue, w_all_we;
  always_comb begin
    bus.instr_ready = (state_q == S_IDLE) && !reset;
    bus.rf_raddr_a  = (state_q == S_IDLE) ? '0 : w_rs1;
    bus.rf_raddr_b  = (state_q == S_IDLE) ? '0 : w_rs2;
    // Reset is folded in so a reset landing in ISSUE never writes the frame.
    w_issue         = (state_q == S_ISSUE) && !bus.frame_stall && !reset;
    w_all_we        = w_issue && !illegal_q;
    bus.illegal_instr = w_issue && illegal_q;
    bus.write_en_we   = w_issue;
    bus.a_op_we       = w_all_we;
    bus.a_loc_we      = w_all_we;
    bus.b_op_we       = w_all_we;
    bus.b_loc_we      = w_all_we;
    bus.imm_we        = w_all_we;
    bus.imm_sel_we    = w_all_we;
    bus.unsigned_we   = w_all_we;
    bus.sub_en_we     = w_all_we;
    bus.result_sel_we = w_all_we;
    bus.write_sel_we  = w_all_we;
  end

  // ---------------- instruction latch --------------------------------------
  always_ff @(posedge clk) begin
    if (reset)                                     instr_q <= '0;
    else if (state_q == S_IDLE && bus.instr_valid) instr_q <= bus.instr_in;
  end

  // ---------------- frame registers ----------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_operand_q    <= '0;
      b_operand_q    <= '0;
      imm_val_q      <= '0;
      a_loc_q        <= '0;
      b_loc_q        <= '0;
      write_sel_q    <= '0;
      imm_sel_q      <= 1'b0;
      unsigned_sel_q <= 1'b0;
      sub_en_q       <= 1'b0;
      write_en_q     <= 1'b0;
      result_sel_q   <= '0;
      illegal_q      <= 1'b0;
    end else if (state_q == S_CAPTURE) begin
      illegal_q <= !w_legal;
      if (w_legal) begin
        a_operand_q    <= w_is_lui ? '0 : w_a_src;
        b_operand_q    <= w_b_src;
        imm_val_q      <= w_imm;
        a_loc_q        <= w_is_lui ? '0 : w_rs1;
        b_loc_q        <= w_rs2;
        write_sel_q    <= w_rd;
        imm_sel_q      <= !w_is_op;
        unsigned_sel_q <= !w_is_lui &&
                          (w_funct3 == 3'b011 || (w_funct3 == 3'b101 && !w_f7b5));
        sub_en_q       <= w_is_op && w_f7b5 && (w_funct3 == 3'b000);
        result_sel_q   <= w_is_lui ? '0 : w_result_sel;
        write_en_q     <= (w_rd != '0);
      end else begin
        // Illegal opcode issues a bubble: only write_en is rewritten.
        write_en_q <= 1'b0;
      end
    end
  end

  assign bus.a_operand    = a_operand_q;
  assign bus.b_operand    = b_operand_q;
  assign bus.imm_val      = imm_val_q;
  assign bus.a_loc        = a_loc_q;
  assign bus.b_loc        = b_loc_q;
  assign bus.write_sel    = write_sel_q;
  assign bus.imm_sel      = imm_sel_q;
  assign bus.unsigned_sel = unsigned_sel_q;
  assign bus.sub_en       = sub_en_q;
  assign bus.write_en     = write_en_q;
  assign bus.result_sel   = result_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_frame_loader
// Description : Self-checking bench for instr_frame_loader. A decode table is
//               pushed through a scoreboard; hand sequences cover stall,
//               reset during CAPTURE and writeback forwarding (expected
//               values follow INSTR_FRAME_FORWARD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_frame_loader;

`ifdef INSTR_FRAME_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_frame_loader_if bus ();

  instr_frame_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic        chk_b;
    logic [31:0] a_op, b_op, imm;
    logic [4:0]  a_loc, b_loc, wsel;
    logic        imm_sel, uns, sub, wen;
    logic [2:0]  rsel;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_legal;
  exp_t        tbl[13];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] regs[32];
  logic [10:0] we_vec;

  assign we_vec = {bus.a_op_we, bus.a_loc_we, bus.b_op_we, bus.b_loc_we,
                   bus.imm_we, bus.imm_sel_we, bus.unsigned_we, bus.sub_en_we,
                   bus.result_sel_we, bus.write_sel_we, bus.write_en_we};

  // Register file model: synchronous 1-cycle read.
  always @(posedge clk) begin
    bus.rf_rdata_a <= regs[bus.rf_raddr_a];
    bus.rf_rdata_b <= regs[bus.rf_raddr_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic legal, input logic chk_b,
                              input logic [31:0] a_op, input logic [31:0] b_op,
                              input logic [31:0] imm, input logic [4:0] a_loc,
                              input logic [4:0] b_loc, input logic [4:0] wsel,
                              input logic imm_sel, input logic uns, input logic sub,
                              input logic wen, input logic [2:0] rsel);
    exp_t e;
    e.instr = instr; e.legal = legal; e.chk_b = chk_b;
    e.a_op = a_op; e.b_op = b_op; e.imm = imm;
    e.a_loc = a_loc; e.b_loc = b_loc; e.wsel = wsel;
    e.imm_sel = imm_sel; e.uns = uns; e.sub = sub; e.wen = wen; e.rsel = rsel;
    return e;
  endfunction

  task automatic cmp_fields(input exp_t e, input bit held);
    chk("a_operand", bus.a_operand, e.a_op);
    chk("a_loc", 32'(bus.a_loc), 32'(e.a_loc));
    if (e.chk_b) begin
      chk("b_operand", bus.b_operand, e.b_op);
      chk("b_loc", 32'(bus.b_loc), 32'(e.b_loc));
    end
    chk("imm_val", bus.imm_val, e.imm);
    chk("write_sel", 32'(bus.write_sel), 32'(e.wsel));
    chk("imm_sel", 32'(bus.imm_sel), 32'(e.imm_sel));
    chk("unsigned_sel", 32'(bus.unsigned_sel), 32'(e.uns));
    chk("sub_en", 32'(bus.sub_en), 32'(e.sub));
    chk("result_sel", 32'(bus.result_sel), 32'(e.rsel));
    if (!held) chk("write_en", 32'(bus.write_en), 32'(e.wen));
  endtask

  // Scoreboard monitor: every frame write pops one expected record.
  always @(negedge clk) begin
    if (!reset && ((|we_vec) || bus.illegal_instr)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_frame_write", 32'(we_vec), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.legal) begin
          chk("we_vec_legal", 32'(we_vec), 32'h7FF);
          chk("illegal_instr_legal", 32'(bus.illegal_instr), 32'h0);
          cmp_fields(e, 1'b0);
          last_legal = e;
        end else begin
          chk("we_vec_bubble", 32'(we_vec), 32'h1);
          chk("illegal_instr", 32'(bus.illegal_instr), 32'h1);
          chk("write_en_bubble", 32'(bus.write_en), 32'h0);
          cmp_fields(last_legal, 1'b1);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins);
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr_in    = ins;
    @(negedge clk);
    chk("ready_before_accept", 32'(bus.instr_ready), 32'h1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.instr_ready) seen = 1'b1;
    end
    if (!seen) chk("wait_idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic clear_last();
    last_legal = mk(32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit any_we;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    regs[0]  = 32'hDEADBEEF;   // x0 must never be read through
    regs[1]  = 32'd5;
    regs[2]  = 32'd7;
    regs[10] = 32'h55;
    regs[31] = 32'h1F1F;
    bus.instr_in = '0; bus.instr_valid = 1'b0; bus.frame_stall = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    clear_last();

    //        instr         lg cb a_op          b_op   imm           al  bl  ws  is un sb we rs
    tbl[0]  = mk(32'h002081B3, 1, 1, 32'd5, 32'd7, 32'h0,        5'd1, 5'd2, 5'd3,  0, 0, 0, 1, 3'd0); // ADD
    tbl[1]  = mk(32'h402081B3, 1, 1, 32'd5, 32'd7, 32'h0,        5'd1, 5'd2, 5'd3,  0, 0, 1, 1, 3'd0); // SUB
    tbl[2]  = mk(32'hFFF00293, 1, 0, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd5,  1, 0, 0, 1, 3'd0); // ADDI x5,x0,-1
    tbl[3]  = mk(32'h12345337, 1, 0, 32'd0, 32'd0, 32'h12345000, 5'd0, 5'd0, 5'd6,  1, 0, 0, 1, 3'd0); // LUI
    tbl[4]  = mk(32'h0000007F, 0, 0, 32'd0, 32'd0, 32'h0,        5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 3'd0); // illegal
    tbl[5]  = mk(32'h0020B233, 1, 1, 32'd5, 32'd7, 32'h0,        5'd1, 5'd2, 5'd4,  0, 1, 0, 1, 3'd4); // SLTU
    tbl[6]  = mk(32'h40315393, 1, 0, 32'd7, 32'd0, 32'd3,        5'd2, 5'd0, 5'd7,  1, 0, 0, 1, 3'd6); // SRAI
    tbl[7]  = mk(32'h00315393, 1, 0, 32'd7, 32'd0, 32'd3,        5'd2, 5'd0, 5'd7,  1, 1, 0, 1, 3'd6); // SRLI
    tbl[8]  = mk(32'h0020C033, 1, 1, 32'd5, 32'd7, 32'h0,        5'd1, 5'd2, 5'd0,  0, 0, 0, 0, 3'd3); // XOR x0
    tbl[9]  = mk(32'h8000F413, 1, 0, 32'd5, 32'd0, 32'hFFFFF800, 5'd1, 5'd0, 5'd8,  1, 0, 0, 1, 3'd1); // ANDI
    tbl[10] = mk(32'h0000E4B3, 1, 1, 32'd5, 32'd0, 32'h0,        5'd1, 5'd0, 5'd9,  0, 0, 0, 1, 3'd2); // OR x9,x1,x0
    tbl[11] = mk(32'h00111533, 1, 1, 32'd7, 32'd5, 32'h0,        5'd2, 5'd1, 5'd10, 0, 0, 0, 1, 3'd5); // SLL
    tbl[12] = mk(32'h0050A593, 1, 0, 32'd5, 32'd0, 32'd5,        5'd1, 5'd0, 5'd11, 1, 0, 0, 1, 3'd4); // SLTI

    // Reset state
    @(negedge clk);
    chk("reset_we", 32'(we_vec), 32'h0);
    chk("reset_a_operand", bus.a_operand, 32'h0);
    chk("reset_ready_low", 32'(bus.instr_ready), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.instr_ready), 32'h1);

    // Decode table with latency check (write enable in 3rd cycle after accept)
    for (int i = 0; i < 13; i++) begin
      sb_q.push_back(tbl[i]);
      issue(tbl[i].instr);
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("latency_write_en_we", 32'(bus.write_en_we), 32'h1);
      wait_idle();
    end

    // Stall for 4 cycles during ISSUE
    sb_q.push_back(tbl[0]);
    bus.frame_stall = 1'b1;
    issue(32'h002081B3);
    any_we = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        any_we = any_we | (|we_vec);
        chk("stall_ready_low", 32'(bus.instr_ready), 32'h0);
      end
    end
    chk("stall_no_we", 32'(any_we), 32'h0);
    @(posedge clk); #1 bus.frame_stall = 1'b0;
    @(negedge clk);
    chk("stall_release_we", 32'(we_vec), 32'h7FF);
    @(negedge clk);
    chk("ready_after_stall", 32'(bus.instr_ready), 32'h1);

    // Reset during CAPTURE aborts the instruction
    issue(32'h402081B3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    clear_last();
    @(negedge clk);
    chk("abort_a_operand", bus.a_operand, 32'h0);
    chk("abort_b_operand", bus.b_operand, 32'h0);
    chk("abort_controls", 32'({bus.a_loc, bus.b_loc, bus.write_sel, bus.imm_sel,
                               bus.unsigned_sel, bus.sub_en, bus.write_en,
                               bus.result_sel, bus.illegal_instr}), 32'h0);
    chk("abort_imm", bus.imm_val, 32'h0);
    chk("abort_we", 32'(we_vec), 32'h0);
    chk("abort_ready", 32'(bus.instr_ready), 32'h1);
    any_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      any_we = any_we | (|we_vec);
    end
    chk("abort_never_issues", 32'(any_we), 32'h0);

    // Writeback forwarding
    bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd99;
    sb_q.push_back(mk(32'h002081B3, 1, 1, FWD ? 32'd99 : 32'd5, 32'd7, 32'h0,
                      5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 3'd0));
    issue(32'h002081B3);
    wait_idle();
    bus.wb_addr = 5'd2;
    sb_q.push_back(mk(32'h002081B3, 1, 1, 32'd5, FWD ? 32'd99 : 32'd7, 32'h0,
                      5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 3'd0));
    issue(32'h002081B3);
    wait_idle();
    bus.wb_addr = 5'd0;
    sb_q.push_back(mk(32'h002001B3, 1, 1, 32'd0, 32'd7, 32'h0,
                      5'd0, 5'd2, 5'd3, 0, 0, 0, 1, 3'd0));
    issue(32'h002001B3);
    wait_idle();
    bus.wb_we = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_frame_loader.md
Name: instr_frame_loader

Overview:
- Issue-side sequencer that fills the per-field instruction frame register.
- Accepts one 32-bit RV32I instruction on a valid/ready handshake and decodes it.
- Reads two source operands from the register file (1-cycle synchronous read).
- Drives every frame field plus its field write-enable in one issue cycle; handles downstream stall, illegal opcodes and optional writeback forwarding.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_ADDR_W, 5, register index width
- RESULT_SEL_W, 3, ALU result-select width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instr_in  in  32  instruction word
- instr_valid  in  1  instr_in valid
- instr_ready  out  1  high only in IDLE and not reset
- rf_raddr_a, rf_raddr_b  out  REG_ADDR_W  RF read addresses (rs1, rs2)
- rf_rdata_a, rf_rdata_b  in  DATA_W  RF read data, valid the cycle after the address
- wb_we  in  1  writeback write strobe
- wb_addr  in  REG_ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- frame_stall  in  1  downstream cannot accept a frame write
- a_operand, b_operand, imm_val  out  DATA_W  frame data
- a_loc, b_loc, write_sel  out  REG_ADDR_W  rs1, rs2, rd
- imm_sel, unsigned_sel, sub_en, write_en  out  1  frame control bits
- result_sel  out  RESULT_SEL_W  ALU function
- a_op_we, a_loc_we, b_op_we, b_loc_we, imm_we, imm_sel_we, unsigned_we, sub_en_we, result_sel_we, write_sel_we, write_en_we  out  1 each  field write enables
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode issue

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: all frame data/control outputs 0, all *_we 0, illegal_instr 0, FSM in IDLE, latched instruction discarded. Reset mid-operation aborts; no write-enable in the cycle after reset.
- FSM is IDLE -> READ -> CAPTURE -> ISSUE -> IDLE.
  - IDLE: instr_ready=1. instr_valid at an edge latches instr_in and moves to READ.
  - READ: rf_raddr_a=instr[19:15], rf_raddr_b=instr[24:20]. rf_raddr_* hold the latched rs values in every non-IDLE state and are 0 in IDLE.
  - CAPTURE: rf_rdata_* and the decode results are registered into the frame outputs.
  - ISSUE: write enables are combinational (state==ISSUE && !frame_stall). While stalled, stay in ISSUE with all *_we 0 and outputs held. Leave for IDLE on the first unstalled cycle.
- Latency and throughput: with no stall, *_we are high in the 3rd cycle after the accepting edge. Throughput is 1 instruction per 4 cycles. No accept while not IDLE.
- Decode, OP (0110011):
  - imm_sel=0, imm_val=0.
  - sub_en = funct7[5] && funct3==000.
- Decode, OP-IMM (0010011):
  - imm_sel=1, sub_en=0.
  - imm_val = sign-extended instr[31:20]; for shifts (funct3 001/101) imm_val = zero-extended instr[24:20].
- Decode, result_sel from funct3:
  - 000 -> 0 (add/sub), 111 -> 1 (and), 110 -> 2 (or), 100 -> 3 (xor).
  - 010 and 011 -> 4 (slt).
  - 001 -> 5 (sll), 101 -> 6 (srl/sra).
- Decode, unsigned_sel = 1 for funct3 011, or funct3 101 with funct7[5]=0.
- Decode, LUI (0110111): a_loc=0, a_operand=0, imm_sel=1, imm_val={instr[31:12],12'b0}, result_sel=0.
- Legal instruction: all 11 *_we asserted together. write_en = (rd != 0).
- Any other opcode is illegal:
  - Only write_en_we is asserted, with write_en=0 (bubble); other fields are held.
  - illegal_instr pulses in the same cycle as the bubble write.
- Register x0: rs=0 always yields operand 0, regardless of rf_rdata or forwarding.

Optional Feature:
- Macro: INSTR_FRAME_FORWARD_EN.
- Defined: in CAPTURE, if wb_we && wb_addr==rs && rs!=0, wb_data is captured instead of rf_rdata. Evaluated independently for a and b.
- Undefined: wb_* ports exist but are ignored; operands always come from rf_rdata.

Test Plan:
- RF x1=5, x2=7; ADD x3,x1,x2 (0x002081B3) -> 3rd cycle after accept: a_operand=5, b_operand=7, a_loc=1, b_loc=2, write_sel=3, result_sel=0, sub_en=0, write_en=1, all 11 we=1 for exactly one cycle.
- SUB x3,x1,x2 (0x402081B3) -> sub_en=1, operands 5/7. Then ADDI x5,x0,-1 (0xFFF00293) -> imm_sel=1, imm_val=0xFFFFFFFF, a_operand=0.
- LUI x6,0x12345 (0x12345337) -> imm_val=0x12345000, a_loc=0, write_sel=6. Opcode 0x0000007F -> only write_en_we=1, write_en=0, illegal_instr=1 for one cycle.
- Hold frame_stall=1 for 4 cycles during ISSUE of ADD -> no we and instr_ready=0 for 4 cycles; we for one cycle on release; instr_ready=1 the next cycle.
- Assert reset in CAPTURE -> next cycle all outputs 0, instr_ready=1 after reset release, and the aborted instruction never issues.
- Forwarding defined: RF x1=5, wb_we=1, wb_addr=1, wb_data=99 in CAPTURE -> a_operand=99. Forwarding undefined -> a_operand=5. wb_addr=0 -> operand 0 in both builds.
